// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel stream multiplexer with external-select or round-robin grant and a registered output stage
module stream_mux_rr #(
    parameter int WIDTH = 4,
    parameter int CH    = 4,
    parameter int SELW  = 2,
    parameter int MODE  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH*WIDTH-1:0]   in_data,
    input  logic [CH-1:0]         in_valid,
    output logic [CH-1:0]         in_ready,
    input  logic [SELW-1:0]       sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic             ld;
    logic             gnt_ok;
    logic [SELW-1:0]  gnt;
    logic [SELW-1:0]  scan_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             gnt_valid;
    logic             xfer;
    logic [SELW-1:0]  last_grant;

    // The output register can take a beat when it is empty or is being drained this cycle
    assign ld = !out_valid || out_ready;

    // Grant: sel directly, or the first requester after last_grant (modulo CH)
    always_comb begin
        gnt_ok   = 1'b0;
        gnt      = '0;
        scan_idx = '0;
        if (MODE == 0) begin
            // A sel value outside 0..CH-1 matches no channel and grants nothing
            for (int i = 0; i < CH; i++) begin
                if (sel == SELW'(i)) begin
                    gnt_ok = 1'b1;
                    gnt    = sel;
                end
            end
        end else begin
            for (int k = 1; k <= CH; k++) begin
                scan_idx = SELW'((int'(last_grant) + k) % CH);
                if (!gnt_ok && in_valid[scan_idx]) begin
                    gnt_ok = 1'b1;
                    gnt    = scan_idx;
                end
            end
        end
    end

    // Data and valid of the granted channel, using constant indices only so sel >= CH stays safe
    always_comb begin
        gnt_data  = '0;
        gnt_valid = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (gnt == SELW'(i)) begin
                gnt_data  = in_data[i*WIDTH +: WIDTH];
                gnt_valid = in_valid[i];
            end
        end
    end

    // Only the granted channel sees ready; held low throughout reset
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CH; i++) begin
            if (rst_n && gnt_ok && ld && (gnt == SELW'(i))) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    assign xfer = rst_n && gnt_ok && ld && gnt_valid;

    // Output register and round-robin pointer; a load and a drain in the same edge keep out_valid high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            last_grant <= SELW'(CH - 1);
        end else if (xfer) begin
            out_valid  <= 1'b1;
            out_data   <= gnt_data;
            out_ch     <= gnt;
            if (MODE == 1) begin
                last_grant <= gnt;
            end
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - randomized and directed bench for stream_mux_rr in both selection modes
module tb_stream_mux_rr;

    localparam int W = 4;
    localparam int N = 4;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [S-1:0]   sel;
    logic           out_ready;

    logic [N-1:0]   rdy0, rdy1;
    logic [W-1:0]   od0, od1;
    logic [S-1:0]   oc0, oc1;
    logic           ov0, ov1;

    int checks   = 0;
    int failures = 0;

    // reference state: the beat each output register should hold, and the last RR winner
    logic           mv [2];
    logic [W-1:0]   md [2];
    int             mc [2];
    int             mlg;

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(W), .CH(N), .SELW(S), .MODE(0)) u_sel (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy0), .sel(sel), .out_data(od0), .out_ch(oc0),
        .out_valid(ov0), .out_ready(out_ready)
    );

    stream_mux_rr #(.WIDTH(W), .CH(N), .SELW(S), .MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy1), .sel(sel), .out_data(od1), .out_ch(oc1),
        .out_valid(ov1), .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // next requester after lg in circular order, or -1 when nobody requests
    function automatic int rr_pick(input int lg, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(lg + k) % N]) return (lg + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mv[d] = 1'b0;
            md[d] = '0;
            mc[d] = 0;
        end
        mlg = N - 1;
    endtask

    task automatic check_outputs();
        check("sel_out_valid", ov0, mv[0]);
        check("sel_out_data",  od0, md[0]);
        check("sel_out_ch",    oc0, mc[0]);
        check("rr_out_valid",  ov1, mv[1]);
        check("rr_out_data",   od1, md[1]);
        check("rr_out_ch",     oc1, mc[1]);
    endtask

    // caller drives inputs just after a falling edge; this checks ready, predicts, clocks, checks outputs
    task automatic cycle();
        int g [2];
        logic ld;
        logic [N-1:0] exp_rdy;
        #1;
        g[0] = (int'(sel) < N) ? int'(sel) : -1;
        g[1] = rr_pick(mlg, in_valid);
        for (int d = 0; d < 2; d++) begin
            ld = !mv[d] || out_ready;
            exp_rdy = (g[d] >= 0 && ld) ? N'(1 << g[d]) : '0;
            check(d == 0 ? "sel_in_ready" : "rr_in_ready", d == 0 ? rdy0 : rdy1, exp_rdy);
            if (g[d] >= 0 && ld && in_valid[g[d]]) begin
                mv[d] = 1'b1;
                md[d] = in_data[g[d]*W +: W];
                mc[d] = g[d];
                if (d == 1) mlg = g[d];
            end else if (out_ready) begin
                mv[d] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] pat [4];
        int seq [4];
        pat[0] = 4'b1010; pat[1] = 4'b0101; pat[2] = 4'b1100; pat[3] = 4'b0011;

        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = '1;
        sel       = '0;
        out_ready = 1'b1;
        model_reset();
        #12;
        check_outputs();
        check("reset_sel_in_ready", rdy0, 0);
        check("reset_rr_in_ready",  rdy1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // external select walks the channels; round-robin with everybody requesting
        in_data = {pat[3], pat[2], pat[1], pat[0]};
        for (int i = 0; i < 6; i++) begin
            sel = S'(i % N);
            cycle();
            check("dir_sel_data", od0, pat[i % N]);
            check("dir_rr_order", oc1, i % N);
        end

        // only ch1 and ch3 request: last winner was 1, so 3 comes first
        in_valid = 4'b1010;
        seq[0] = 3; seq[1] = 1; seq[2] = 3; seq[3] = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("dir_rr_alt", oc1, seq[i]);
        end

        // back-pressure: 1111 from ch0 held while the consumer stalls, then ch1 0000 follows at once
        in_valid = 4'b0001;
        in_data  = 16'h000F;
        cycle();
        check("bp_load_ch", oc1, 0);
        in_valid  = 4'b0011;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_hold_data", od1, 4'hF);
            check("bp_hold_ready", rdy1, 0);
        end
        out_ready = 1'b1;
        in_valid  = 4'b0010;
        cycle();
        check("bp_next_ch", oc1, 1);
        check("bp_next_data", od1, 0);
        check("bp_next_valid", ov1, 1);

        // idle after a ch2 grant, then ch0 and ch3 request: ch3 wins first
        in_valid = 4'b0100;
        in_data  = 16'h0A00;
        cycle();
        in_valid = '0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("idle_drained", ov1, 0);
        end
        in_valid = 4'b1001;
        in_data  = 16'h7006;
        cycle();
        check("idle_first_ch3", oc1, 3);
        cycle();
        check("idle_then_ch0", oc1, 0);

        // random traffic, back-pressure and selects
        for (int i = 0; i < 400; i++) begin
            in_data   = N*W'($urandom);
            in_valid  = N'($urandom);
            sel       = S'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // asynchronous reset with a beat in the output register
        in_valid  = '1;
        in_data   = 16'h9E7D;
        out_ready = 1'b1;
        sel       = 2'd2;
        cycle();
        check("pre_reset_valid", ov1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("mid_reset_sel_ready", rdy0, 0);
        check("mid_reset_rr_ready",  rdy1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        check("post_reset_first_ch0", oc1, 0);
        cycle();
        check("post_reset_second_ch1", oc1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
